// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Read tags travel alongside each granted access so returning data can be steered.
package mem_arb_pkg;

  typedef logic port_id_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  localparam int READ_LATENCY = 2;

  typedef struct packed {
    logic     valid;
    port_id_t port_id;
    logic     is_read;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the shared memory port.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) ();

  logic                  req0;
  logic                  lock0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  lock1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, lock1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_data,
    input  mem_rdata
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, lock1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_data,
    output mem_rdata
  );

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
// Masked-off requests are ignored; on contention the port not granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_id_t   i_last,
  input  logic [1:0] i_mask,
  output logic [1:0] o_gnt
);

  logic [1:0] w_req;

  assign w_req = i_req & i_mask;

  always_comb begin
    o_gnt = 2'b00;
    case (w_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between two requesters with round-robin
// arbitration, ownership locking, registered memory outputs and tagged read return.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FIRST_PORT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  arb_state_t            r_state;
  port_id_t              r_owner;
  port_id_t              r_last;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  tag_t                  r_tag [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic [1:0]            w_req;
  logic [1:0]            w_lock;
  logic [1:0]            w_mask;
  logic [1:0]            w_gnt;
  logic                  w_release;
  logic                  w_any_gnt;
  port_id_t              w_gnt_port;
  logic                  w_gnt_we;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  tag_t                  w_tag_in;
  tag_t                  w_tag_out;
  logic                  w_rvalid0;
  logic                  w_rvalid1;

  // An idle, unlocked owner frees the arbiter immediately so the other port is not stalled a cycle.
  always_comb begin
    w_req     = {bus.req1, bus.req0};
    w_lock    = {bus.lock1, bus.lock0};
    w_release = (r_state == ARB_LOCKED) && !w_req[r_owner] && !w_lock[r_owner];
    w_mask    = 2'b11;
    if ((r_state == ARB_LOCKED) && !w_release) begin
      w_mask = r_owner ? 2'b10 : 2'b01;
    end
  end

  arb_rr2 u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .i_mask (w_mask),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_any_gnt        = |w_gnt;
    w_gnt_port       = w_gnt[1];
    w_gnt_we         = w_gnt_port ? bus.we1    : bus.we0;
    w_gnt_addr       = w_gnt_port ? bus.addr1  : bus.addr0;
    w_gnt_data       = w_gnt_port ? bus.wdata1 : bus.wdata0;
    w_tag_in.valid   = w_any_gnt;
    w_tag_in.port_id = w_gnt_port;
    w_tag_in.is_read = !w_gnt_we;
  end

  // Pointer resets to the opposite of FIRST_PORT so FIRST_PORT wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_OPEN;
      r_owner <= 1'b0;
      r_last  <= port_id_t'(FIRST_PORT == 0);
    end else if (w_any_gnt) begin
      r_last <= w_gnt_port;
      if (w_lock[w_gnt_port]) begin
        r_state <= ARB_LOCKED;
        r_owner <= w_gnt_port;
      end else begin
        r_state <= ARB_OPEN;
      end
    end else if (w_release) begin
      r_state <= ARB_OPEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_mem_we <= w_any_gnt && w_gnt_we;
      if (w_any_gnt) begin
        r_mem_addr <= w_gnt_addr;
        r_mem_data <= w_gnt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_tag_out = r_tag[READ_LATENCY-1];
  assign w_rvalid0 = w_tag_out.valid && w_tag_out.is_read && (w_tag_out.port_id == 1'b0);
  assign w_rvalid1 = w_tag_out.valid && w_tag_out.is_read && (w_tag_out.port_id == 1'b1);

  // Memory data is only valid in the return cycle, so it bypasses to the port then and is held after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_rvalid0) r_rdata0 <= bus.mem_rdata;
      if (w_rvalid1) r_rdata1 <= bus.mem_rdata;
    end
  end

  assign bus.gnt0     = w_gnt[0];
  assign bus.gnt1     = w_gnt[1];
  assign bus.rvalid0  = w_rvalid0;
  assign bus.rvalid1  = w_rvalid1;
  assign bus.rdata0   = w_rvalid0 ? bus.mem_rdata : r_rdata0;
  assign bus.rdata1   = w_rvalid1 ? bus.mem_rdata : r_rdata1;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives both ports from the falling edge,
// models a one-cycle synchronous memory and checks against hand-computed values.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   nAsserts = 0;
  int   nFail = 0;

  bit [15:0] mem [64];
  bit        written [64];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH (6),
    .DATA_WIDTH (16),
    .FIRST_PORT (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] initWord(input logic [5:0] a);
    case (a)
      6'd1:    return 16'h0111;
      6'd2:    return 16'h0222;
      6'd8:    return 16'h1234;
      6'd9:    return 16'h5678;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Memory returns the word addressed in the previous cycle; unwritten words come from initWord.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_data;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr] : initWord(bus.mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input logic r0, input logic l0, input logic w0, input logic [5:0] a0,
                             input logic [15:0] d0, input logic r1, input logic l1, input logic w1,
                             input logic [5:0] a1, input logic [15:0] d1);
    bus.req0 = r0; bus.lock0 = l0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.lock1 = l1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic applyStimulus(input logic r0, input logic l0, input logic w0, input logic [5:0] a0,
                               input logic [15:0] d0, input logic r1, input logic l1, input logic w1,
                               input logic [5:0] a1, input logic [15:0] d1);
    @(negedge clk);
    driveInputs(r0, l0, w0, a0, d0, r1, l1, w1, a1, d1);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 6'd0, 16'h0, 0, 0, 0, 6'd0, 16'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    driveInputs(0, 0, 0, 6'd0, 16'h0, 0, 0, 0, 6'd0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    driveInputs(0, 0, 0, 6'd0, 16'h0, 0, 0, 0, 6'd0, 16'h0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_data", bus.mem_data, 0);
    checkOutput("rst_rvalid0", bus.rvalid0, 0);
    checkOutput("rst_rvalid1", bus.rvalid1, 0);
    checkOutput("rst_rdata0", bus.rdata0, 0);
    checkOutput("rst_rdata1", bus.rdata1, 0);
    checkOutput("rst_gnt0", bus.gnt0, 0);
    checkOutput("rst_gnt1", bus.gnt1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single port 0 read");
    applyStimulus(1, 0, 0, 6'd8, 16'h0, 0, 0, 0, 6'd0, 16'h0);
    checkOutput("rd_gnt0", bus.gnt0, 1);
    checkOutput("rd_gnt1", bus.gnt1, 0);
    idleCycle();
    checkOutput("rd_mem_addr", bus.mem_addr, 8);
    checkOutput("rd_mem_we", bus.mem_we, 0);
    checkOutput("rd_rvalid0_early", bus.rvalid0, 0);
    checkOutput("rd_rvalid1_a", bus.rvalid1, 0);
    idleCycle();
    checkOutput("rd_rvalid0", bus.rvalid0, 1);
    checkOutput("rd_rdata0", bus.rdata0, 16'h1234);
    checkOutput("rd_rvalid1_b", bus.rvalid1, 0);
    idleCycle();
    checkOutput("rd_rvalid0_late", bus.rvalid0, 0);

    $display("[TB] round-robin contention");
    doReset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(1, 0, 0, 6'd1, 16'h0, 1, 0, 0, 6'd2, 16'h0);
      else       idleCycle();
      checkOutput($sformatf("rr_gnt0_%0d", k), bus.gnt0, (k < 4) && (k % 2 == 0));
      checkOutput($sformatf("rr_gnt1_%0d", k), bus.gnt1, (k < 4) && (k % 2 == 1));
      if (k >= 1 && k <= 4) checkOutput($sformatf("rr_mem_addr_%0d", k), bus.mem_addr, (k % 2 == 1) ? 1 : 2);
      checkOutput($sformatf("rr_rvalid0_%0d", k), bus.rvalid0, (k == 2) || (k == 4));
      checkOutput($sformatf("rr_rvalid1_%0d", k), bus.rvalid1, (k == 3) || (k == 5));
      if (k == 2 || k == 4) checkOutput($sformatf("rr_rdata0_%0d", k), bus.rdata0, 16'h0111);
      if (k == 3 || k == 4 || k == 5) checkOutput($sformatf("rr_rdata1_%0d", k), bus.rdata1, 16'h0222);
    end

    $display("[TB] port 1 write then port 0 readback");
    applyStimulus(0, 0, 0, 6'd0, 16'h0, 1, 0, 1, 6'd5, 16'hBEEF);
    checkOutput("wr_gnt1", bus.gnt1, 1);
    checkOutput("wr_gnt0", bus.gnt0, 0);
    idleCycle();
    checkOutput("wr_mem_we", bus.mem_we, 1);
    checkOutput("wr_mem_addr", bus.mem_addr, 5);
    checkOutput("wr_mem_data", bus.mem_data, 16'hBEEF);
    applyStimulus(1, 0, 0, 6'd5, 16'h0, 0, 0, 0, 6'd0, 16'h0);
    checkOutput("wr_mem_we_drop", bus.mem_we, 0);
    checkOutput("wr_no_rvalid1", bus.rvalid1, 0);
    checkOutput("wb_gnt0", bus.gnt0, 1);
    idleCycle();
    checkOutput("wb_mem_addr", bus.mem_addr, 5);
    checkOutput("wb_mem_we", bus.mem_we, 0);
    idleCycle();
    checkOutput("wb_rvalid0", bus.rvalid0, 1);
    checkOutput("wb_rdata0", bus.rdata0, 16'hBEEF);

    $display("[TB] locked two-word fetch");
    doReset();
    applyStimulus(1, 1, 0, 6'd8, 16'h0, 1, 0, 0, 6'd2, 16'h0);
    checkOutput("lk_gnt0_a", bus.gnt0, 1);
    checkOutput("lk_gnt1_a", bus.gnt1, 0);
    applyStimulus(1, 0, 0, 6'd9, 16'h0, 1, 0, 0, 6'd2, 16'h0);
    checkOutput("lk_gnt0_b", bus.gnt0, 1);
    checkOutput("lk_gnt1_b", bus.gnt1, 0);
    applyStimulus(0, 0, 0, 6'd0, 16'h0, 1, 0, 0, 6'd2, 16'h0);
    checkOutput("lk_gnt1_c", bus.gnt1, 1);
    checkOutput("lk_gnt0_c", bus.gnt0, 0);
    checkOutput("lk_mem_addr_c", bus.mem_addr, 9);
    checkOutput("lk_rvalid0_c", bus.rvalid0, 1);
    checkOutput("lk_rdata0_c", bus.rdata0, 16'h1234);
    idleCycle();
    checkOutput("lk_rvalid0_d", bus.rvalid0, 1);
    checkOutput("lk_rdata0_d", bus.rdata0, 16'h5678);
    checkOutput("lk_mem_addr_d", bus.mem_addr, 2);
    idleCycle();
    checkOutput("lk_rvalid1_e", bus.rvalid1, 1);
    checkOutput("lk_rdata1_e", bus.rdata1, 16'h0222);
    checkOutput("lk_rvalid0_e", bus.rvalid0, 0);

    $display("[TB] locked owner idles");
    applyStimulus(1, 1, 0, 6'd1, 16'h0, 1, 0, 0, 6'd2, 16'h0);
    checkOutput("idl_gnt0", bus.gnt0, 1);
    checkOutput("idl_gnt1", bus.gnt1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 6'd0, 16'h0, 1, 0, 0, 6'd2, 16'h0);
      checkOutput($sformatf("idl_hold_gnt1_%0d", i), bus.gnt1, 0);
      checkOutput($sformatf("idl_hold_gnt0_%0d", i), bus.gnt0, 0);
    end
    applyStimulus(0, 0, 0, 6'd0, 16'h0, 1, 0, 0, 6'd2, 16'h0);
    checkOutput("idl_release_gnt1", bus.gnt1, 1);
    idleCycle();
    checkOutput("idl_mem_addr", bus.mem_addr, 2);
    checkOutput("idl_mem_we", bus.mem_we, 0);
    idleCycle();
    idleCycle();

    $display("[TB] reset during locked read");
    applyStimulus(1, 1, 0, 6'd8, 16'h0, 0, 0, 0, 6'd0, 16'h0);
    checkOutput("mr_gnt0", bus.gnt0, 1);
    @(negedge clk);
    driveInputs(0, 1, 0, 6'd0, 16'h0, 0, 0, 0, 6'd0, 16'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_mem_we", bus.mem_we, 0);
    checkOutput("mr_mem_addr", bus.mem_addr, 0);
    checkOutput("mr_mem_data", bus.mem_data, 0);
    checkOutput("mr_rvalid0_a", bus.rvalid0, 0);
    @(negedge clk);
    #1;
    checkOutput("mr_rvalid0_b", bus.rvalid0, 0);
    checkOutput("mr_rdata0", bus.rdata0, 0);
    checkOutput("mr_rvalid1", bus.rvalid1, 0);
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 6'd0, 16'h0, 1, 0, 0, 6'd2, 16'h0);
    checkOutput("mr_open_gnt1", bus.gnt1, 1);
    checkOutput("mr_open_gnt0", bus.gnt0, 0);
    idleCycle();
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
